// File: rtl/bank_account_server.sv
// bank_account_server: single-account ATM server with PIN auth, lockout and a
// valid/ready request/response handshake through an IDLE/EXEC/RESP FSM.
module bank_account_server #(
  parameter logic [31:0] INIT_BALANCE = 32'h000F4240,
  parameter logic [3:0]  ACCT_PIN     = 4'b1010,
  parameter int          MAX_TRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [3:0]  req_pin_i,
  input  logic [31:0] req_amount_i,
  input  logic        session_end_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [1:0]  rsp_code_o,
  output logic [31:0] rsp_balance_o,
  output logic        authed_o,
  output logic        locked_o
);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam logic [1:0] OK = 2'b00, BAD_PIN = 2'b01, FUNDS = 2'b10, DENIED = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   bal_q, bal_d, amt_q, amt_d, rbal_q, rbal_d;
  logic [1:0]    op_q, op_d, code_q, code_d;
  logic [3:0]    pin_q, pin_d;
  logic [FW-1:0] fails_q, fails_d;
  logic          authed_q, authed_d, locked_q, locked_d, auth;
  logic [32:0]   sum;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bal_q    <= INIT_BALANCE;
      amt_q    <= '0;
      rbal_q   <= '0;
      op_q     <= '0;
      code_q   <= '0;
      pin_q    <= '0;
      fails_q  <= '0;
      authed_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bal_q    <= bal_d;
      amt_q    <= amt_d;
      rbal_q   <= rbal_d;
      op_q     <= op_d;
      code_q   <= code_d;
      pin_q    <= pin_d;
      fails_q  <= fails_d;
      authed_q <= authed_d;
      locked_q <= locked_d;
    end
  end
  // A session_end coinciding with the EXEC edge makes the request unauthenticated.
  assign auth = authed_q & ~session_end_i;
  assign sum  = {1'b0, bal_q} + {1'b0, amt_q};
  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    amt_d    = amt_q;
    rbal_d   = rbal_q;
    op_d     = op_q;
    code_d   = code_q;
    pin_d    = pin_q;
    fails_d  = fails_q;
    authed_d = authed_q;
    locked_d = locked_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        op_d    = req_op_i;
        pin_d   = req_pin_i;
        amt_d   = req_amount_i;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
        code_d  = DENIED;
        rbal_d  = '0;
        if (!locked_q) begin
          if (op_q == 2'b00) begin
            if (pin_q == ACCT_PIN) begin
              authed_d = 1'b1;
              fails_d  = '0;
              code_d   = OK;
              rbal_d   = bal_q;
            end else begin
              authed_d = 1'b0;
              fails_d  = fails_q + 1'b1;
              locked_d = (fails_d == FW'(MAX_TRIES));
              code_d   = locked_d ? DENIED : BAD_PIN;
            end
          end else if (auth) begin
            code_d = OK;
            rbal_d = bal_q;
            if (op_q == 2'b10) begin
              code_d = sum[32] ? FUNDS : OK;
              bal_d  = sum[32] ? bal_q : sum[31:0];
              rbal_d = bal_d;
            end else if (op_q == 2'b11) begin
              code_d = (amt_q > bal_q) ? FUNDS : OK;
              bal_d  = (amt_q > bal_q) ? bal_q : bal_q - amt_q;
              rbal_d = bal_d;
            end
          end
        end
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (session_end_i) authed_d = 1'b0;
  end
  assign req_ready_o   = (state_q == IDLE) & rst_ni;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_code_o    = code_q;
  assign rsp_balance_o = rbal_q;
  assign authed_o      = authed_q;
  assign locked_o      = locked_q;
endmodule

// File: tb/tb_bank_account_server.sv
// tb_bank_account_server: directed stimulus with a queue scoreboard drained by
// a monitor on every response handshake.
module tb_bank_account_server;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        req_valid = 1'b0, session_end = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_pin = '0;
  logic [31:0] req_amount = '0;
  logic        req_ready, rsp_valid, authed, locked;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_balance;
  int tests = 0, fails = 0;
  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] bal;
    logic        a;
    logic        l;
  } exp_t;
  exp_t sb[$];
  localparam logic [1:0] OK = 2'b00, BP = 2'b01, FU = 2'b10, DN = 2'b11;
  localparam logic [31:0] INIT = 32'd1000000;

  bank_account_server dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_pin_i(req_pin), .req_amount_i(req_amount),
    .session_end_i(session_end), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_code_o(rsp_code), .rsp_balance_o(rsp_balance), .authed_o(authed), .locked_o(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_ni && rsp_valid && rsp_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: code=%b bal=%h with empty scoreboard", rsp_code, rsp_balance);
      end else begin
        exp_t e, got;
        e   = sb.pop_front();
        got = '{code: rsp_code, bal: rsp_balance, a: authed, l: locked};
        if (got !== e) begin
          fails++;
          $display("FAIL resp: got code=%b bal=%h authed=%b locked=%b, want code=%b bal=%h authed=%b locked=%b",
                   got.code, got.bal, got.a, got.l, e.code, e.bal, e.a, e.l);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] pin, input logic [31:0] amt);
    bit done = 0;
    req_op = op; req_pin = pin; req_amount = amt; req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) begin
        @(posedge clk); #1 req_valid = 1'b0;
        done = 1;
      end else @(negedge clk);
    end
    if (!done) begin
      req_valid = 1'b0;
      check("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = req_ready;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic [1:0] op, input logic [3:0] pin, input logic [31:0] amt,
                     input logic [1:0] c, input logic [31:0] b, input logic a, input logic l);
    sb.push_back('{code: c, bal: b, a: a, l: l});
    send(op, pin, amt);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  hc;
    logic [31:0] hb;
    #3;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_flags", {30'd0, authed, locked}, 0);
    check("rst_rsp", {30'd0, rsp_code} | rsp_balance, 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 1);
    // good PIN with latency check
    sb.push_back('{code: OK, bal: INIT, a: 1'b1, l: 1'b0});
    send(2'b00, 4'b1010, 0);
    check("exec_no_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check("resp_valid_lat", 32'(rsp_valid), 1);
    check("authed_after_pin", 32'(authed), 1);
    wait_idle();
    txn(2'b11, 0, 32'd1000001, FU, INIT, 1, 0);
    txn(2'b11, 0, 32'd1000000, OK, 0, 1, 0);
    txn(2'b10, 0, 0, OK, 0, 1, 0);
    txn(2'b11, 0, 0, OK, 0, 1, 0);
    txn(2'b10, 0, 32'hFFFFFFF0, OK, 32'hFFFFFFF0, 1, 0);
    txn(2'b10, 0, 32'h20, FU, 32'hFFFFFFF0, 1, 0);
    txn(2'b10, 0, 32'hF, OK, 32'hFFFFFFFF, 1, 0);
    txn(2'b01, 0, 0, OK, 32'hFFFFFFFF, 1, 0);
    // session_end on the EXEC edge, response held for 5 cycles
    rsp_ready = 1'b0;
    sb.push_back('{code: DN, bal: 0, a: 1'b0, l: 1'b0});
    send(2'b01, 0, 0);
    session_end = 1'b1;
    @(posedge clk); #1 session_end = 1'b0;
    hc = rsp_code; hb = rsp_balance;
    check("sess_code", 32'(hc), 32'(DN));
    req_valid = 1'b1; req_op = 2'b10; req_amount = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_rsp", {30'd0, rsp_code} ^ rsp_balance, {30'd0, hc} ^ hb);
      check("hold_ready", 32'(req_ready), 0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();
    txn(2'b01, 0, 0, DN, 0, 0, 0);
    // reset while holding a response
    txn(2'b00, 4'b1010, 0, OK, 32'hFFFFFFFF, 1, 0);
    rst_ni = 1'b0; #1;
    rst_ni = 1'b1;
    wait_idle();
    txn(2'b00, 4'b1010, 0, OK, INIT, 1, 0);
    rsp_ready = 1'b0;
    send(2'b10, 0, 32'd5);
    @(posedge clk); #1;
    check("dep5_resp_valid", 32'(rsp_valid), 1);
    check("dep5_bal", rsp_balance, INIT + 5);
    #2 rst_ni = 1'b0; #1;
    check("async_rst_valid", 32'(rsp_valid), 0);
    check("async_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1 rst_ni = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(req_ready), 1);
    txn(2'b00, 4'b1010, 0, OK, INIT, 1, 0);
    // lockout: a good PIN clears the counter
    txn(2'b00, 4'b0001, 0, BP, 0, 0, 0);
    txn(2'b00, 4'b0001, 0, BP, 0, 0, 0);
    txn(2'b00, 4'b1010, 0, OK, INIT, 1, 0);
    txn(2'b00, 4'b0001, 0, BP, 0, 0, 0);
    txn(2'b00, 4'b0001, 0, BP, 0, 0, 0);
    txn(2'b00, 4'b0001, 0, DN, 0, 0, 1);
    txn(2'b00, 4'b1010, 0, DN, 0, 0, 1);
    txn(2'b10, 0, 32'd1, DN, 0, 0, 1);
    check("sb_drained", 32'(sb.size()), 0);
    rst_ni = 1'b0; #1;
    check("rst_clears_lock", 32'(locked), 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
